// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: a main entry driving execute plus one skid entry, so
// id_ready is a flop output and never depends combinationally on ex_ready.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_data,
  input  logic [REG_W-1:0]  id_reg,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_data,
  output logic [REG_W-1:0]  ex_reg,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and ready is taken only from flops.

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [REG_W-1:0]  main_reg_q, main_reg_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [REG_W-1:0]  skid_reg_q, skid_reg_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic consume;
  logic main_free;

  assign id_ready  = !skid_valid_q;
  assign ex_valid  = main_valid_q;
  assign ex_data   = main_data_q;
  assign ex_reg    = main_reg_q;
  assign stall_cnt = stall_cnt_q;

  assign accept    = id_valid && id_ready;
  assign consume   = main_valid_q && ex_ready;
  assign main_free = !main_valid_q || consume;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_reg_d   = main_reg_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_reg_d   = skid_reg_q;
    stall_cnt_d  = stall_cnt_q;

    if (main_valid_q && !ex_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (flush) begin
      // A consume this cycle has already completed; everything else is dropped.
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_reg_d   = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_reg_d   = '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_reg_d   = skid_reg_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = id_data;
          skid_reg_d  = id_reg;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = id_data;
          main_reg_d  = id_reg;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = id_data;
      skid_reg_d   = id_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_reg_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_reg_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_reg_q   <= main_reg_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_reg_q   <= skid_reg_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against an occupancy-queue
// model; a second instance with a 4-bit counter exercises saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_data;
  logic [4:0]  id_reg;
  logic        flush;
  logic        ex_ready;

  logic        id_ready, ex_valid;
  logic [31:0] ex_data;
  logic [4:0]  ex_reg;
  logic [15:0] stall_cnt;

  logic        s_id_ready, s_ex_valid;
  logic [31:0] s_ex_data;
  logic [4:0]  s_ex_reg;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_data(id_data), .id_reg(id_reg), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_data(ex_data), .ex_reg(ex_reg), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(s_id_ready),
    .id_data(id_data), .id_reg(id_reg), .flush(flush), .ex_valid(s_ex_valid),
    .ex_ready(ex_ready), .ex_data(s_ex_data), .ex_reg(s_ex_reg), .stall_cnt(s_stall_cnt)
  );

  // Model: instructions held by the stage, oldest first, as {reg, data}.
  logic [36:0] exp_q[$];
  logic [31:0] last_data;
  logic [4:0]  last_reg;
  int unsigned exp_cnt;
  int unsigned exp_cnt4;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ed;
    logic [4:0]  er;
    ed = (exp_q.size() > 0) ? exp_q[0][31:0]  : last_data;
    er = (exp_q.size() > 0) ? exp_q[0][36:32] : last_reg;
    check("ex_valid",   {31'b0, ex_valid}, {31'b0, exp_q.size() > 0});
    check("id_ready",   {31'b0, id_ready}, {31'b0, exp_q.size() < 2});
    check("ex_data",    ex_data, ed);
    check("ex_reg",     {27'b0, ex_reg}, {27'b0, er});
    check("stall_cnt",  {16'b0, stall_cnt}, exp_cnt);
    check("s_ex_valid", {31'b0, s_ex_valid}, {31'b0, exp_q.size() > 0});
    check("s_id_ready", {31'b0, s_id_ready}, {31'b0, exp_q.size() < 2});
    check("s_ex_data",  s_ex_data, ed);
    check("s_ex_reg",   {27'b0, s_ex_reg}, {27'b0, er});
    check("s_stall",    {28'b0, s_stall_cnt}, exp_cnt4);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc, con;
    acc = id_valid && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && ex_ready;
    if (!reset) begin
      exp_q.delete();
      last_data = '0;
      last_reg  = '0;
      exp_cnt   = 0;
      exp_cnt4  = 0;
    end else begin
      if (exp_q.size() > 0 && !ex_ready) begin
        if (exp_cnt  < 65535) exp_cnt++;
        if (exp_cnt4 < 15)    exp_cnt4++;
      end
      if (con) begin
        last_data = exp_q[0][31:0];
        last_reg  = exp_q[0][36:32];
        void'(exp_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
        last_data = '0;
        last_reg  = '0;
      end else if (acc) begin
        exp_q.push_back({id_reg, id_data});
      end
    end
  endtask

  task automatic cycle(input logic rst_i, input logic fl_i, input logic iv_i,
                       input logic [31:0] d_i, input logic [4:0] r_i, input logic er_i);
    check_outputs();
    reset    = rst_i;
    flush    = fl_i;
    id_valid = iv_i;
    id_data  = d_i;
    id_reg   = r_i;
    ex_ready = er_i;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; id_valid = 1'b1; id_data = 32'hFFFFFFFF;
    id_reg = 5'h1F; ex_ready = 1'b1;
    exp_cnt = 0; exp_cnt4 = 0; last_data = '0; last_reg = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with a valid input offered.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'h1F, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'h1F, 1'b1);
    check("rst_ex_data", ex_data, 32'h0);
    check("rst_id_ready", {31'b0, id_ready}, 32'h1);

    // Streaming back-to-back.
    cycle(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 5'b10101, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, 5'b01010, 1'b1);
    check("stream_1", ex_data, 32'h5A5A5A5A);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);

    // Back-pressure: #1 into main, #2 into skid, #3 waits for id_ready.
    cycle(1'b1, 1'b0, 1'b1, 32'h1111_0001, 5'd1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h2222_0002, 5'd2, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'h3333_0003, 5'd3, 1'b0);
    check("bp_id_ready", {31'b0, id_ready}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h3333_0003, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);

    // Flush with both entries full and a new instruction offered.
    cycle(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 5'd11, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hAAAA_0002, 5'd12, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd13, 1'b1);
    check("flush_ex_data", ex_data, 32'h0);
    check("flush_ex_valid", {31'b0, ex_valid}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);

    // Saturation: 20 stalled cycles after a fresh reset.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'hC0DE_0001, 5'd7, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0);
    check("sat_cnt4", {28'b0, s_stall_cnt}, 32'd15);
    check("sat_cnt16", {16'b0, stall_cnt}, 32'd20);

    // Reset with the skid full and stall_cnt at 7.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'hBEEF_0001, 5'd21, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hBEEF_0002, 5'd22, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0);
    check("mid_cnt7", {16'b0, stall_cnt}, 32'd7);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    check("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
    check("mid_rst_cnt", {16'b0, stall_cnt}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7),
            $urandom(),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) < 6));
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline stage with a valid/ready handshake, a two-entry skid buffer, a synchronous flush and a saturating stall counter. It sits between the decode and execute stages. It replaces a plain clocked register with a stage that can hold data while execute back-pressures, can drop in-flight instructions on a branch or exception flush, and sustains one transfer per cycle without a combinational ready path from EX to ID.

## Interface
- DATA_W, 32, width of the decoded operand/data payload
- REG_W, 5, width of the destination register index
- CNT_W, 16, width of the stall counter
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- id_valid  input  1  decode presents a valid instruction
- id_ready  output  1  stage can accept; registered, not combinational from ex_ready
- id_data  input  DATA_W  decode payload
- id_reg  input  REG_W  decode destination register
- flush  input  1  discard all held and incoming instructions this cycle
- ex_valid  output  1  ex_data/ex_reg hold a valid instruction
- ex_ready  input  1  execute consumes when ex_valid is also 1
- ex_data  output  DATA_W  payload to execute
- ex_reg  output  REG_W  destination register to execute
- stall_cnt  output  CNT_W  cycles spent with ex_valid=1 and ex_ready=0

## Operation
- Storage: main entry (drives ex_*) and skid entry, each with its own valid bit.
- Accept: id_valid && id_ready. Consume: ex_valid && ex_ready.
- id_ready = !skid_valid, registered.
- Per cycle, when flush=0:
  - Main empty or consumed, skid valid: main <- skid; skid <- input if accepted, else skid empties.
  - Main empty or consumed, skid empty: main <- input if accepted, else main empties.
  - Main held (valid, not consumed), input accepted: skid <- input.
  - Main held, no accept: no change.
- Ordering is strict FIFO; an instruction is never duplicated or dropped without a flush.
- Emptied main entry: ex_valid=0, ex_data/ex_reg hold their last value.
- Flush (flush=1, reset deasserted):
  - Both valid bits clear.
  - ex_data, ex_reg and skid data cleared to 0.
  - Any instruction accepted in the same cycle is discarded.
  - A consume in the flush cycle still counts as a completed transfer to EX.
  - stall_cnt is unaffected.
- stall_cnt:
  - +1 on every cycle with ex_valid=1 && ex_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset has priority over flush and all transfers.

## Timing
- Reset values: ex_valid=0, ex_data=0, ex_reg=0, stall_cnt=0, skid empty, id_ready=1 on the first cycle after reset releases.
- Latency: an instruction accepted at edge N appears on ex_* with ex_valid=1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while ex_ready=1.
- Back-pressure: when ex_ready drops with a full main entry, the stage absorbs one more accept into skid. id_ready is 0 in the cycle after the skid fills.
- Reasserting ex_ready: skid moves to main on that edge. id_ready returns to 1 the following cycle.
- Flush: ex_valid=0 and id_ready=1 after the flush edge. The next accept may occur in the cycle after flush.
- Reset asserted mid-stall or mid-burst: all state returns to reset values at that edge. There is no partial drain.

## Test plan
- Reset: hold reset=0 for 2 cycles with id_valid=1 and id_data=32'hFFFFFFFF -> ex_valid=0, ex_data=0, ex_reg=0, stall_cnt=0, id_ready=1 after release.
- Streaming: ex_ready=1, send A5A5A5A5/5'b10101 then 5A5A5A5A/5'b01010 on back-to-back cycles -> each appears on ex_* exactly one cycle after its accept, in order, with ex_valid=1 on both cycles.
- Back-pressure:
  - Stimulus: ex_ready=0 from the cycle after the first accept, three instructions offered back-to-back.
  - Response: main holds #1, skid holds #2, id_ready=0 so #3 is not accepted; stall_cnt increments once per stalled cycle.
  - Then ex_ready=1: #1, #2, #3 are delivered in order with no loss.
- Flush: with main and skid both full and id_valid=1, pulse flush for one cycle -> next cycle ex_valid=0, ex_data=0, ex_reg=0, id_ready=1, the flush-cycle input never appears, stall_cnt unchanged.
- Saturation: CNT_W=4, hold ex_valid=1 and ex_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Reset mid-operation: assert reset while the skid is full and stall_cnt=7 -> all outputs return to reset values at that edge, and the held instructions are never delivered.
